// File: rtl/yarvi_commit_pkg.sv
// Shared definitions for the yarvi commit stage: privilege encodings and
// trace record layout {priv, pc, insn, rd, val}, MSB first.
package yarvi_commit_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_e;

    localparam int unsigned PRIV_W = 2;
    localparam int unsigned INSN_W = 32;
    localparam int unsigned RD_W   = 5;

    // Field LSB offsets inside a trace record; consumers unpack with these.
    function automatic int unsigned trace_val_lsb();
        return 0;
    endfunction

    function automatic int unsigned trace_rd_lsb(input int unsigned xlen);
        return xlen;
    endfunction

    function automatic int unsigned trace_insn_lsb(input int unsigned xlen);
        return xlen + RD_W;
    endfunction

    function automatic int unsigned trace_pc_lsb(input int unsigned xlen);
        return xlen + RD_W + INSN_W;
    endfunction

    function automatic int unsigned trace_priv_lsb(input int unsigned xlen, input int unsigned vlen);
        return xlen + RD_W + INSN_W + vlen;
    endfunction

    function automatic int unsigned trace_w(input int unsigned xlen, input int unsigned vlen);
        return xlen + RD_W + INSN_W + vlen + PRIV_W;
    endfunction

endpackage

// File: rtl/yarvi_commit_fifo.sv
// Generic DEPTH x W circular buffer with push/pop, full/empty flags.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module yarvi_commit_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    import yarvi_commit_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_head];

    // Storage deliberately has no reset; only the pointers define validity.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_tail] <= i_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + AW'(1);
            if (w_do_pop)  r_head <= r_head + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/yarvi_commit.sv
// ME/commit stage: registers EX result, counts instret, buffers a trace FIFO.
// Optional commit signature enabled by defining YARVI_COMMIT_SIG_EN.
module yarvi_commit
    import yarvi_commit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned VLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ex_valid,
    input  logic [1:0]                    ex_priv,
    input  logic [VLEN-1:0]               ex_pc,
    input  logic [31:0]                   ex_insn,
    input  logic [4:0]                    ex_wb_rd,
    input  logic [XLEN-1:0]               ex_wb_val,
    output logic                          me_valid,
    output logic [1:0]                    me_priv,
    output logic [VLEN-1:0]               me_pc,
    output logic [31:0]                   me_insn,
    output logic [4:0]                    me_wb_rd,
    output logic [XLEN-1:0]               me_wb_val,
    output logic [63:0]                   instret,
    output logic                          trace_valid,
    input  logic                          trace_ready,
    output logic [2+VLEN+32+5+XLEN-1:0]   trace_data,
    output logic [15:0]                   trace_drops,
    output logic [XLEN-1:0]               sig
);
    localparam int unsigned TW = trace_w(XLEN, VLEN);

    logic [XLEN-1:0] w_wb_val;
    logic [TW-1:0]   w_rec;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_drop;

    assign w_wb_val    = (ex_wb_rd != 5'd0) ? ex_wb_val : '0;
    assign w_rec       = {ex_priv, ex_pc, ex_insn, ex_wb_rd, w_wb_val};
    assign trace_valid = ~w_empty;
    assign w_pop       = trace_valid & trace_ready;
    assign w_drop      = ex_valid & w_full & ~w_pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            me_valid  <= 1'b0;
            me_priv   <= '0;
            me_pc     <= '0;
            me_insn   <= '0;
            me_wb_rd  <= '0;
            me_wb_val <= '0;
        end else begin
            me_valid <= ex_valid;
            if (ex_valid) begin
                me_priv   <= ex_priv;
                me_pc     <= ex_pc;
                me_insn   <= ex_insn;
                me_wb_rd  <= ex_wb_rd;
                me_wb_val <= w_wb_val;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instret     <= '0;
            trace_drops <= '0;
        end else begin
            if (ex_valid) instret <= instret + 64'd1;
            if (w_drop && trace_drops != 16'hFFFF) trace_drops <= trace_drops + 16'd1;
        end
    end

`ifdef YARVI_COMMIT_SIG_EN
    logic [XLEN-1:0] r_sig;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sig <= '0;
        end else if (ex_valid) begin
            r_sig <= {r_sig[XLEN-2:0], r_sig[XLEN-1]} ^ XLEN'(ex_pc) ^ XLEN'(ex_insn);
        end
    end

    assign sig = r_sig;
`else
    assign sig = '0;
`endif

    yarvi_commit_fifo #(
        .DEPTH (DEPTH),
        .W     (TW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (ex_valid),
        .i_pop   (w_pop),
        .i_data  (w_rec),
        .o_data  (trace_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_yarvi_commit.sv
// Directed self-checking bench for yarvi_commit (XLEN=VLEN=32, DEPTH=4).
module tb_yarvi_commit;
    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         ex_valid = 1'b0;
    logic [1:0]   ex_priv = '0;
    logic [31:0]  ex_pc = '0;
    logic [31:0]  ex_insn = '0;
    logic [4:0]   ex_wb_rd = '0;
    logic [31:0]  ex_wb_val = '0;
    logic         me_valid;
    logic [1:0]   me_priv;
    logic [31:0]  me_pc;
    logic [31:0]  me_insn;
    logic [4:0]   me_wb_rd;
    logic [31:0]  me_wb_val;
    logic [63:0]  instret;
    logic         trace_valid;
    logic         trace_ready = 1'b0;
    logic [102:0] trace_data;
    logic [15:0]  trace_drops;
    logic [31:0]  sig;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    yarvi_commit #(.XLEN(32), .VLEN(32), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_priv(ex_priv),
        .ex_pc(ex_pc), .ex_insn(ex_insn), .ex_wb_rd(ex_wb_rd), .ex_wb_val(ex_wb_val),
        .me_valid(me_valid), .me_priv(me_priv), .me_pc(me_pc), .me_insn(me_insn),
        .me_wb_rd(me_wb_rd), .me_wb_val(me_wb_val), .instret(instret),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
        .trace_drops(trace_drops), .sig(sig)
    );

    // Hand-placed record fields: val[31:0] rd[36:32] insn[68:37] pc[100:69] priv[102:101]
    wire [31:0] t_val  = trace_data[31:0];
    wire [4:0]  t_rd   = trace_data[36:32];
    wire [31:0] t_insn = trace_data[68:37];
    wire [31:0] t_pc   = trace_data[100:69];
    wire [1:0]  t_priv = trace_data[102:101];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        ex_valid = 1'b0; trace_ready = 1'b0; reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] insn,
                         input logic [4:0] rd, input logic [31:0] val, input logic [1:0] priv);
        ex_valid = 1'b1; ex_pc = pc; ex_insn = insn; ex_wb_rd = rd; ex_wb_val = val; ex_priv = priv;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tests++; if (me_valid !== 1'b0) begin fails++; $display("FAIL reset_me_valid got %0h exp 0", me_valid); end
        tests++; if (me_wb_val !== 32'h0) begin fails++; $display("FAIL reset_me_wb_val got %0h exp 0", me_wb_val); end
        tests++; if (instret !== 64'h0) begin fails++; $display("FAIL reset_instret got %0h exp 0", instret); end
        tests++; if (trace_valid !== 1'b0) begin fails++; $display("FAIL reset_trace_valid got %0h exp 0", trace_valid); end
        tests++; if (trace_drops !== 16'h0) begin fails++; $display("FAIL reset_drops got %0h exp 0", trace_drops); end
        tests++; if (sig !== 32'h0) begin fails++; $display("FAIL reset_sig got %0h exp 0", sig); end
        reset = 1'b1;
    endtask

    task automatic test_single_commit();
        do_reset();
        trace_ready = 1'b1;
        drive(32'h8000_0000, 32'h0050_0093, 5'd1, 32'd5, 2'd3);
        tick();
        ex_valid = 1'b0;
        tests++; if (me_valid !== 1'b1) begin fails++; $display("FAIL single_me_valid got %0h exp 1", me_valid); end
        tests++; if (me_wb_rd !== 5'd1) begin fails++; $display("FAIL single_me_rd got %0h exp 1", me_wb_rd); end
        tests++; if (me_wb_val !== 32'd5) begin fails++; $display("FAIL single_me_val got %0h exp 5", me_wb_val); end
        tests++; if (me_pc !== 32'h8000_0000) begin fails++; $display("FAIL single_me_pc got %0h exp 80000000", me_pc); end
        tests++; if (me_priv !== 2'd3) begin fails++; $display("FAIL single_me_priv got %0h exp 3", me_priv); end
        tests++; if (instret !== 64'd1) begin fails++; $display("FAIL single_instret got %0h exp 1", instret); end
        tests++; if (trace_valid !== 1'b1) begin fails++; $display("FAIL single_trace_valid got %0h exp 1", trace_valid); end
        tests++; if (t_pc !== 32'h8000_0000) begin fails++; $display("FAIL single_rec_pc got %0h exp 80000000", t_pc); end
        tests++; if (t_insn !== 32'h0050_0093) begin fails++; $display("FAIL single_rec_insn got %0h exp 00500093", t_insn); end
        tests++; if (t_rd !== 5'd1) begin fails++; $display("FAIL single_rec_rd got %0h exp 1", t_rd); end
        tests++; if (t_val !== 32'd5) begin fails++; $display("FAIL single_rec_val got %0h exp 5", t_val); end
        tests++; if (t_priv !== 2'd3) begin fails++; $display("FAIL single_rec_priv got %0h exp 3", t_priv); end
        tick();
        tests++; if (trace_valid !== 1'b0) begin fails++; $display("FAIL single_popped got %0h exp 0", trace_valid); end
        tests++; if (me_valid !== 1'b0) begin fails++; $display("FAIL single_me_idle got %0h exp 0", me_valid); end
        tests++; if (me_wb_val !== 32'd5) begin fails++; $display("FAIL single_me_hold got %0h exp 5", me_wb_val); end
        tests++; if (instret !== 64'd1) begin fails++; $display("FAIL single_instret_hold got %0h exp 1", instret); end
    endtask

    task automatic test_x0_suppression();
        do_reset();
        trace_ready = 1'b0;
        drive(32'h0000_1000, 32'h0000_0013, 5'd0, 32'hDEAD_BEEF, 2'd0);
        tick();
        ex_valid = 1'b0;
        tests++; if (me_wb_val !== 32'h0) begin fails++; $display("FAIL x0_me_val got %0h exp 0", me_wb_val); end
        tests++; if (me_wb_rd !== 5'd0) begin fails++; $display("FAIL x0_me_rd got %0h exp 0", me_wb_rd); end
        tests++; if (t_val !== 32'h0) begin fails++; $display("FAIL x0_rec_val got %0h exp 0", t_val); end
        tests++; if (t_pc !== 32'h0000_1000) begin fails++; $display("FAIL x0_rec_pc got %0h exp 1000", t_pc); end
    endtask

    task automatic test_overflow();
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(32'h100 + 32'(4 * i), 32'h13, 5'd2, 32'(i + 1), 2'd0);
            tick();
        end
        ex_valid = 1'b0;
        tests++; if (trace_drops !== 16'd2) begin fails++; $display("FAIL ovf_drops got %0d exp 2", trace_drops); end
        tests++; if (instret !== 64'd6) begin fails++; $display("FAIL ovf_instret got %0d exp 6", instret); end
        tick();
        tests++; if (t_pc !== 32'h100) begin fails++; $display("FAIL ovf_head_stable got %0h exp 100", t_pc); end
        trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (trace_valid !== 1'b1 || t_pc !== 32'h100 + 32'(4 * i))
                begin fails++; $display("FAIL ovf_pop%0d got v=%0h pc=%0h exp v=1 pc=%0h", i, trace_valid, t_pc, 32'h100 + 32'(4 * i)); end
            tick();
        end
        tests++; if (trace_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty got %0h exp 0", trace_valid); end
    endtask

    task automatic test_full_with_pop();
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h200 + 32'(4 * i), 32'h13, 5'd3, 32'h0, 2'd1);
            tick();
        end
        drive(32'h210, 32'h13, 5'd3, 32'h0, 2'd1);
        trace_ready = 1'b1;
        tick();
        ex_valid = 1'b0;
        tests++; if (trace_drops !== 16'd0) begin fails++; $display("FAIL fullpop_drops got %0d exp 0", trace_drops); end
        for (int i = 1; i < 5; i++) begin
            tests++; if (trace_valid !== 1'b1 || t_pc !== 32'h200 + 32'(4 * i))
                begin fails++; $display("FAIL fullpop_pop%0d got v=%0h pc=%0h exp v=1 pc=%0h", i, trace_valid, t_pc, 32'h200 + 32'(4 * i)); end
            tick();
        end
        tests++; if (trace_valid !== 1'b0) begin fails++; $display("FAIL fullpop_empty got %0h exp 0", trace_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        trace_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(32'h400 + 32'(4 * i), 32'h13, 5'd4, 32'(i), 2'd0);
            tick();
            tests++; if (trace_valid !== 1'b1 || t_pc !== 32'h400 + 32'(4 * i))
                begin fails++; $display("FAIL b2b_%0d got v=%0h pc=%0h exp v=1 pc=%0h", i, trace_valid, t_pc, 32'h400 + 32'(4 * i)); end
        end
        ex_valid = 1'b0;
        tick();
        tests++; if (trace_valid !== 1'b0 || trace_drops !== 16'd0)
            begin fails++; $display("FAIL b2b_drain got v=%0h drops=%0d exp v=0 drops=0", trace_valid, trace_drops); end
        tests++; if (instret !== 64'd5) begin fails++; $display("FAIL b2b_instret got %0d exp 5", instret); end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h500 + 32'(4 * i), 32'h0010_0093, 5'd1, 32'h55, 2'd3);
            tick();
        end
        tests++; if (trace_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid got %0h exp 1", trace_valid); end
        #2 reset = 1'b0;
        #1;
        tests++; if ({me_valid, me_priv, me_pc, me_insn, me_wb_rd, me_wb_val} !== '0)
            begin fails++; $display("FAIL mid_me_zero got v=%0h pc=%0h val=%0h exp 0", me_valid, me_pc, me_wb_val); end
        tests++; if (instret !== 64'd0 || trace_drops !== 16'd0 || sig !== 32'd0)
            begin fails++; $display("FAIL mid_cnt_zero got instret=%0h drops=%0h sig=%0h exp 0", instret, trace_drops, sig); end
        tests++; if (trace_valid !== 1'b0) begin fails++; $display("FAIL mid_valid_zero got %0h exp 0", trace_valid); end
        tick();
        tests++; if (me_valid !== 1'b0 || instret !== 64'd0 || trace_valid !== 1'b0)
            begin fails++; $display("FAIL mid_held got me_v=%0h instret=%0h tv=%0h exp 0", me_valid, instret, trace_valid); end
        reset = 1'b1;
        drive(32'h600, 32'h13, 5'd7, 32'h77, 2'd0);
        tick();
        ex_valid = 1'b0;
        tests++; if (trace_valid !== 1'b1 || t_pc !== 32'h600)
            begin fails++; $display("FAIL mid_first got v=%0h pc=%0h exp v=1 pc=600", trace_valid, t_pc); end
        tests++; if (instret !== 64'd1) begin fails++; $display("FAIL mid_instret got %0d exp 1", instret); end
        trace_ready = 1'b1;
        tick();
        tests++; if (trace_valid !== 1'b0) begin fails++; $display("FAIL mid_only_one got %0h exp 0", trace_valid); end
    endtask

    task automatic test_signature();
        logic [31:0] exp1;
        logic [31:0] exp2;
`ifdef YARVI_COMMIT_SIG_EN
        exp1 = 32'h17;
        exp2 = 32'h35;
`else
        exp1 = 32'h0;
        exp2 = 32'h0;
`endif
        do_reset();
        trace_ready = 1'b1;
        drive(32'h4, 32'h13, 5'd0, 32'h0, 2'd0);
        tick();
        tests++; if (sig !== exp1) begin fails++; $display("FAIL sig_first got %0h exp %0h", sig, exp1); end
        drive(32'h8, 32'h13, 5'd0, 32'h0, 2'd0);
        tick();
        ex_valid = 1'b0;
        tests++; if (sig !== exp2) begin fails++; $display("FAIL sig_second got %0h exp %0h", sig, exp2); end
        tick();
        tests++; if (sig !== exp2) begin fails++; $display("FAIL sig_hold got %0h exp %0h", sig, exp2); end
    endtask

    initial begin
        test_reset();
        test_single_commit();
        test_x0_suppression();
        test_overflow();
        test_full_with_pop();
        test_back_to_back();
        test_reset_mid_stream();
        test_signature();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/yarvi_commit.md
# yarvi_commit

Parametrised ME/commit stage that sits after `yarvi_ex` and replaces the ad-hoc writeback registers in the core top. It registers the EX result into the ME stage and suppresses writes to x0. It keeps a 64-bit retired-instruction counter. It also buffers every committed instruction in a DEPTH-entry trace FIFO with a valid/ready handshake, for disassembly, co-simulation or debug consumers.

## Interface
Parameters:
- `XLEN`, 32, data width; `yarvi.h` `XMSB` equals XLEN-1.
- `VLEN`, 32, PC width; `VMSB` equals VLEN-1.
- `DEPTH`, 4, trace FIFO entries; must be a power of two and at least 2.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low.
- `ex_valid`  in  1  EX holds a completing instruction.
- `ex_priv`  in  2  privilege level of that instruction.
- `ex_pc`  in  VLEN  its PC.
- `ex_insn`  in  32  its encoding.
- `ex_wb_rd`  in  5  destination register; 0 means none.
- `ex_wb_val`  in  XLEN  writeback value.
- `me_valid`  out  1  ME stage holds a committed instruction.
- `me_priv`  out  2  registered copy of `ex_priv`.
- `me_pc`  out  VLEN  registered copy of `ex_pc`.
- `me_insn`  out  32  registered copy of `ex_insn`.
- `me_wb_rd`  out  5  registered rd.
- `me_wb_val`  out  XLEN  registered writeback value.
- `instret`  out  64  count of committed instructions.
- `trace_valid`  out  1  FIFO head is valid.
- `trace_ready`  in  1  consumer accepts the head.
- `trace_data`  out  2+VLEN+32+5+XLEN  head record, packed {priv, pc, insn, rd, val}, MSB first.
- `trace_drops`  out  16  number of records lost because the FIFO was full.
- `sig`  out  XLEN  commit signature; tied to 0 without `YARVI_COMMIT_SIG_EN`.

## Operation
- **ME register.** Every cycle: `me_valid <= ex_valid`.
  - When `ex_valid` is 1, load priv, pc and insn from the EX inputs.
  - Load `me_wb_rd` as `ex_wb_rd`.
  - Load `me_wb_val` as `ex_wb_val` when rd≠0, otherwise load 0.
  - When `ex_valid` is 0, the payload registers hold their value.
- **instret.** Increments by 1 on each cycle where `ex_valid` is 1. Wraps modulo 2^64 with no flag.
- **Trace FIFO.** Circular buffer with head and tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
  - pop = `trace_valid & trace_ready`.
  - push = `ex_valid`. The record is built from the EX inputs, with rd=0 forcing val to 0 as above.
  - A push is accepted when count < DEPTH, or when pop is also 1 in the same cycle (a full FIFO with simultaneous pop accepts the push).
  - A rejected push is dropped and `trace_drops` increments, saturating at 0xFFFF. The ME register and `instret` are never affected by FIFO state.
  - Pointers wrap from DEPTH-1 to 0.
  - count updates: +1 on accepted push without pop, -1 on pop without push, unchanged on both or neither.
- `trace_valid` = (count ≠ 0). `trace_data` is the entry at head.
  - No empty-FIFO bypass.
  - While `trace_valid` is 1 and `trace_ready` is 0, `trace_data` holds stable.
- **Reset** (asserted low at any time, including mid-transfer):
  - `me_*` outputs go to 0.
  - `instret`, `trace_drops`, `sig`, the pointers and count go to 0, so `trace_valid` is 0.
  - FIFO storage is not reset.

## Timing
- EX to `me_*` latency: 1 cycle.
- EX to `trace_valid` latency: 1 cycle when the FIFO was empty.
- `instret` reflects a commit 1 cycle after `ex_valid`, i.e. it is coincident with `me_valid`.
- Pop takes effect at the clock edge where `trace_valid & trace_ready` is 1. The next record appears in the following cycle.
- No combinational path from any input to any output. In particular, `trace_valid` does not depend on `trace_ready` in the same cycle.
- Sustained throughput is 1 record per cycle when `trace_ready` is held at 1.

## Configuration
- `YARVI_COMMIT_SIG_EN` defined:
  - On each cycle where `ex_valid` is 1, `sig <= {sig[XLEN-2:0], sig[XLEN-1]} ^ zext(ex_pc) ^ zext(ex_insn)`.
  - Update is visible 1 cycle later; reset value is 0.
- Undefined: `sig` is constant 0, no signature register is synthesised, and the port list is unchanged.

## Structure
- Shared header `yarvi.h` holds:
  - `XMSB` and `VMSB`;
  - the privilege encodings (U=0, S=1, M=3);
  - macros for the trace record field offsets, so the disassembler and co-sim unpack records consistently.
- One sub-module, `yarvi_commit_fifo`, holds the generic DEPTH×W circular buffer with push/pop, count and full/empty flags. Drop counting and record packing stay in `yarvi_commit`.

## Test plan
- **Single commit.** Stimulus: `ex_valid`=1, pc=0x80000000, insn=0x00500093, rd=1, val=5, `trace_ready`=1. Required response next cycle:
  - `me_valid`=1, `me_wb_rd`=1, `me_wb_val`=5;
  - `instret`=1;
  - `trace_valid`=1, and the record decodes to the same values.
- **x0 suppression.** Stimulus: rd=0, val=0xDEADBEEF. Required: `me_wb_val`=0 and record val=0.
- **Overflow.** Stimulus: DEPTH=4, `trace_ready`=0, 6 back-to-back commits. Required:
  - count=4 and `trace_drops`=2;
  - `instret`=6;
  - popping yields the first 4 PCs in order.
- **Full with simultaneous pop.** Stimulus: FIFO full, `ex_valid`=1 and `trace_ready`=1 in the same cycle. Required: no drop, count stays 4, new record lands at the wrapped tail.
- **Reset mid-stream.** Stimulus: `reset` driven low while count=3 and `trace_valid`=1. Required: all outputs 0 while `reset` is low; after release, the first commit appears as the only record.
- **Signature.** Stimulus: with `YARVI_COMMIT_SIG_EN` defined, commit pc=0x4, insn=0x13, then pc=0x8, insn=0x13. Required: `sig`=0x17, then 0x2E ^ 0x8 ^ 0x13 = 0x35. With the macro undefined, `sig` stays 0.
